// File: rtl/rect_fill_pkg.sv
// Shared types for the rectangle fill engine: command record, FSM states, screen defaults.
package rect_fill_pkg;

  localparam int SCREEN_W_DEFAULT = 160;
  localparam int SCREEN_H_DEFAULT = 120;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] w;
    logic [6:0] h;
    logic [2:0] colour;
  } rect_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAW
  } fill_state_t;

endpackage

// File: rtl/rect_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible on dout while not empty.
// Pushes when full and pops when empty are ignored.
module rect_cmd_fifo
  import rect_fill_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  rect_cmd_t din,
  output rect_cmd_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  rect_cmd_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rect_fill_engine.sv
// Queued rectangle filler: one pixel per cycle in raster order to a VGA pixel-write port.
// Optional macro RECT_FILL_CLIP_EN suppresses off-screen plots instead of wrapping coordinates.
module rect_fill_engine
  import rect_fill_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = SCREEN_W_DEFAULT,
  parameter int SCREEN_H   = SCREEN_H_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_x,
  input  logic [6:0] cmd_y,
  input  logic [7:0] cmd_w,
  input  logic [6:0] cmd_h,
  input  logic [2:0] cmd_colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy
);

  fill_state_t state;
  rect_cmd_t   cur;
  rect_cmd_t   head;
  rect_cmd_t   incoming;
  logic        full;
  logic        empty;
  logic        pop;

  logic [7:0]  col;
  logic [6:0]  row;
  logic [7:0]  col_inc;
  logic [6:0]  row_inc;
  logic [7:0]  next_col;
  logic [6:0]  next_row;
  logic        last_pixel;
  logic [8:0]  px;
  logic [7:0]  py;
  logic        on_screen;

  assign incoming  = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, colour: cmd_colour};
  assign cmd_ready = !full && !reset;
  assign pop       = (state == IDLE) && !empty;
  assign busy      = !empty || (state != IDLE);

  rect_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid && cmd_ready),
    .pop   (pop),
    .din   (incoming),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // col/row track the pixel currently on the port; next_* is the one registered next.
  always_comb begin
    col_inc    = col + 8'd1;
    row_inc    = row + 7'd1;
    last_pixel = (col_inc == cur.w) && (row_inc == cur.h);
    next_col   = col_inc;
    next_row   = row;
    if (state == LOAD) begin
      next_col = 8'd0;
      next_row = 7'd0;
    end else if (col_inc == cur.w) begin
      next_col = 8'd0;
      next_row = row_inc;
    end
    px = {1'b0, cur.x} + {1'b0, next_col};
    py = {1'b0, cur.y} + {1'b0, next_row};
  end

`ifdef RECT_FILL_CLIP_EN
  localparam logic [8:0] CLIP_X = 9'(SCREEN_W);
  localparam logic [7:0] CLIP_Y = 8'(SCREEN_H);
  assign on_screen = (px < CLIP_X) && (py < CLIP_Y);
`else
  assign on_screen = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur        <= '0;
      col        <= '0;
      row        <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vga_plot <= 1'b0;
          if (!empty) begin
            cur   <= head;
            state <= LOAD;
          end
        end
        LOAD: begin
          col <= 8'd0;
          row <= 7'd0;
          if (cur.w == 8'd0 || cur.h == 7'd0) begin
            state <= IDLE;
          end else begin
            state    <= DRAW;
            vga_plot <= on_screen;
            if (on_screen) begin
              vga_x      <= 8'(px % 9'd256);
              vga_y      <= 7'(py % 8'd128);
              vga_colour <= cur.colour;
            end
          end
        end
        DRAW: begin
          if (last_pixel) begin
            state    <= IDLE;
            vga_plot <= 1'b0;
          end else begin
            col      <= next_col;
            row      <= next_row;
            vga_plot <= on_screen;
            if (on_screen) begin
              vga_x      <= 8'(px % 9'd256);
              vga_y      <= 7'(py % 8'd128);
              vga_colour <= cur.colour;
            end
          end
        end
        default: begin
          state    <= IDLE;
          vga_plot <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: plot order, latency, backpressure, degenerate, wrap/clip, reset.
module tb_rect_fill_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_x = '0;
  logic [6:0] cmd_y = '0;
  logic [7:0] cmd_w = '0;
  logic [6:0] cmd_h = '0;
  logic [2:0] cmd_colour = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int px_q[$];
  int py_q[$];
  int pc_q[$];
  int pt_q[$];

  rect_fill_engine #(.FIFO_DEPTH(4), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_colour (cmd_colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vga_plot) begin
      px_q.push_back(int'(vga_x));
      py_q.push_back(int'(vga_y));
      pc_q.push_back(int'(vga_colour));
      pt_q.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_plot(input int i, input int x, input int y, input int c);
    chk($sformatf("plot%0d_x", i), 32'(px_q[i]), 32'(x));
    chk($sformatf("plot%0d_y", i), 32'(py_q[i]), 32'(y));
    chk($sformatf("plot%0d_c", i), 32'(pc_q[i]), 32'(c));
  endtask

  // Called at a negedge; returns the cycle index in which the command was accepted.
  task automatic push_cmd(input int x, input int y, input int w, input int h, input int c,
                          output int acc);
    cmd_x = 8'(x); cmd_y = 7'(y); cmd_w = 8'(w); cmd_h = 7'(h); cmd_colour = 3'(c);
    cmd_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      if (cmd_ready) begin
        acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(output int t);
    t = -1;
    for (int i = 0; i < 3000; i++) begin
      if (!busy) begin
        t = cyc;
        return;
      end
      @(negedge clk);
    end
    chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_q();
    px_q.delete(); py_q.delete(); pc_q.delete(); pt_q.delete();
  endtask

  int a0, a1, a2, a3, t;
  int ex[8];
  int ey[8];

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_plot", 32'(vga_plot), 32'd0);
    chk("rst_x", 32'(vga_x), 32'd0);
    chk("rst_y", 32'(vga_y), 32'd0);
    chk("rst_colour", 32'(vga_colour), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // Single 3x2 rectangle.
    clear_q();
    push_cmd(30, 85, 3, 2, 6, a0);
    wait_idle(t);
    chk("single_count", 32'(px_q.size()), 32'd6);
    ex = '{30, 31, 32, 30, 31, 32, 0, 0};
    ey = '{85, 85, 85, 86, 86, 86, 0, 0};
    for (int i = 0; i < 6; i++) chk_plot(i, ex[i], ey[i], 6);
    chk("single_latency", 32'(pt_q[0] - a0), 32'd3);
    chk("single_busy_fall", 32'(t - a0), 32'd9);
    chk("hold_x", 32'(vga_x), 32'd32);
    chk("hold_y", 32'(vga_y), 32'd86);
    chk("hold_plot", 32'(vga_plot), 32'd0);

    // Backpressure: four 1x1 commands queue behind a 5x1 fill, the fifth stalls.
    clear_q();
    push_cmd(100, 10, 5, 1, 7, a0);
    for (int i = 0; i < 4; i++) push_cmd(10 + i, 20, 1, 1, i + 1, a1);
    chk("full_ready_low", 32'(cmd_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    push_cmd(14, 20, 1, 1, 5, a2);
    chk("fifth_accept", 32'(a2 - a0), 32'd9);
    wait_idle(t);
    chk("bp_count", 32'(px_q.size()), 32'd10);
    for (int i = 0; i < 5; i++) chk_plot(i, 100 + i, 10, 7);
    for (int i = 0; i < 5; i++) chk_plot(5 + i, 10 + i, 20, i + 1);

    // Zero-width command is skipped; the next one is unaffected.
    clear_q();
    push_cmd(40, 40, 0, 5, 1, a0);
    push_cmd(50, 60, 1, 1, 5, a1);
    wait_idle(t);
    chk("zero_count", 32'(px_q.size()), 32'd1);
    chk_plot(0, 50, 60, 5);
    chk("zero_follow_latency", 32'(pt_q[0] - a1), 32'd4);

    // Right/bottom screen edge.
    clear_q();
    push_cmd(158, 119, 4, 2, 3, a0);
    wait_idle(t);
    chk("edge_draw_cycles", 32'(t - a0), 32'd11);
`ifdef RECT_FILL_CLIP_EN
    chk("edge_count", 32'(px_q.size()), 32'd2);
    chk_plot(0, 158, 119, 3);
    chk_plot(1, 159, 119, 3);
    chk("edge_hold_x", 32'(vga_x), 32'd159);
`else
    chk("edge_count", 32'(px_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk_plot(i, 158 + (i % 4), 119 + (i / 4), 3);
`endif

    // Coordinates past 255/127.
    clear_q();
    push_cmd(254, 127, 4, 2, 2, a0);
    wait_idle(t);
    chk("wrap_draw_cycles", 32'(t - a0), 32'd11);
`ifdef RECT_FILL_CLIP_EN
    chk("wrap_count", 32'(px_q.size()), 32'd0);
`else
    chk("wrap_count", 32'(px_q.size()), 32'd8);
    ex = '{254, 255, 0, 1, 254, 255, 0, 1};
    ey = '{127, 127, 127, 127, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) chk_plot(i, ex[i], ey[i], 2);
`endif

    // Reset on the third pixel of a 10x10 fill with two commands queued.
    clear_q();
    push_cmd(5, 5, 10, 10, 4, a0);
    push_cmd(1, 1, 2, 2, 1, a1);
    push_cmd(2, 2, 2, 2, 2, a3);
    t = 0;
    for (int i = 0; i < 100; i++) begin
      if (vga_plot && vga_x == 8'd7 && vga_y == 7'd5) begin
        t = 1;
        break;
      end
      @(negedge clk);
    end
    chk("third_pixel_seen", 32'(t), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_plot", 32'(vga_plot), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_x", 32'(vga_x), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    clear_q();
    repeat (40) @(negedge clk);
    chk("post_rst_no_plots", 32'(px_q.size()), 32'd0);
    chk("post_rst_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
